// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - 3-stage radix-2 DIT/DIF complex butterfly with valid/ready flow control
// Optional output saturation and sticky overflow flag: define BUTTERFLY_PIPE_SAT_EN
module butterfly_pipe #(
    parameter int DW   = 24,
    parameter int TW   = 16,
    parameter int FRAC = 13
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] xp_real,
    input  logic signed [DW-1:0] xp_imag,
    input  logic signed [DW-1:0] xq_real,
    input  logic signed [DW-1:0] xq_imag,
    input  logic signed [TW-1:0] factor_real,
    input  logic signed [TW-1:0] factor_imag,
    input  logic                 mode,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] yp_real,
    output logic signed [DW-1:0] yp_imag,
    output logic signed [DW-1:0] yq_real,
    output logic signed [DW-1:0] yq_imag,
    input  logic                 ovf_clr,
    output logic                 ovf
);

    // Two headroom bits above the full-precision butterfly sum plus one for the rounding add.
    localparam int AW = DW + TW + 3;
    typedef logic signed [AW-1:0] wide_t;

    function automatic wide_t round_k(input wide_t v, input logic [7:0] k);
        wide_t one;
        wide_t r;
        one    = '0;
        one[0] = 1'b1;
        if (k == 8'd0) r = v;
        else           r = (v + (one <<< (k - 8'd1))) >>> k;
        return r;
    endfunction

    function automatic logic out_of_range(input wide_t v);
        return (|v[AW-1:DW-1]) && !(&v[AW-1:DW-1]);
    endfunction

    function automatic logic signed [DW-1:0] narrow(input wide_t v);
`ifdef BUTTERFLY_PIPE_SAT_EN
        if (out_of_range(v)) return v[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
        return v[DW-1:0];
    endfunction

    logic  adv;
    logic  out_valid_q;

    logic  v1_q, m1_q, sc1_q;
    wide_t a_r1_q, a_i1_q, b_r1_q, b_i1_q;
    wide_t p_rr1_q, p_ii1_q, p_ri1_q, p_ir1_q;
    logic signed [TW-1:0] w_r1_q, w_i1_q;
    wide_t a_r1_d, a_i1_d, b_r1_d, b_i1_d;
    wide_t p_rr1_d, p_ii1_d, p_ri1_d, p_ir1_d;

    logic  v2_q, m2_q, sc2_q;
    wide_t ypr2_q, ypi2_q, yqr2_q, yqi2_q;
    wide_t ypr2_d, ypi2_d, yqr2_d, yqi2_d;

    wide_t rpr, rpi, rqr, rqi;
    logic [7:0] kp, kq;
    logic  any_oor;

    logic signed [DW-1:0] ypr_q, ypi_q, yqr_q, yqi_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Stage 1: DIT forms the four partial products of xq*W, DIF forms xp+xq and xp-xq.
    always_comb begin
        a_r1_d  = '0;
        a_i1_d  = '0;
        b_r1_d  = '0;
        b_i1_d  = '0;
        p_rr1_d = '0;
        p_ii1_d = '0;
        p_ri1_d = '0;
        p_ir1_d = '0;
        if (!mode) begin
            a_r1_d  = AW'(xp_real);
            a_i1_d  = AW'(xp_imag);
            p_rr1_d = AW'(xq_real) * AW'(factor_real);
            p_ii1_d = AW'(xq_imag) * AW'(factor_imag);
            p_ri1_d = AW'(xq_real) * AW'(factor_imag);
            p_ir1_d = AW'(xq_imag) * AW'(factor_real);
        end else begin
            a_r1_d  = AW'(xp_real) + AW'(xq_real);
            a_i1_d  = AW'(xp_imag) + AW'(xq_imag);
            b_r1_d  = AW'(xp_real) - AW'(xq_real);
            b_i1_d  = AW'(xp_imag) - AW'(xq_imag);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q    <= 1'b0;
            m1_q    <= 1'b0;
            sc1_q   <= 1'b0;
            a_r1_q  <= '0;
            a_i1_q  <= '0;
            b_r1_q  <= '0;
            b_i1_q  <= '0;
            p_rr1_q <= '0;
            p_ii1_q <= '0;
            p_ri1_q <= '0;
            p_ir1_q <= '0;
            w_r1_q  <= '0;
            w_i1_q  <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            if (in_valid) begin
                m1_q    <= mode;
                sc1_q   <= scale;
                a_r1_q  <= a_r1_d;
                a_i1_q  <= a_i1_d;
                b_r1_q  <= b_r1_d;
                b_i1_q  <= b_i1_d;
                p_rr1_q <= p_rr1_d;
                p_ii1_q <= p_ii1_d;
                p_ri1_q <= p_ri1_d;
                p_ir1_q <= p_ir1_d;
                w_r1_q  <= factor_real;
                w_i1_q  <= factor_imag;
            end
        end
    end

    // Stage 2: DIT adds/subtracts t against xp scaled up to twiddle precision; DIF multiplies the difference.
    always_comb begin
        ypr2_d = '0;
        ypi2_d = '0;
        yqr2_d = '0;
        yqi2_d = '0;
        if (!m1_q) begin
            ypr2_d = (a_r1_q <<< FRAC) + (p_rr1_q - p_ii1_q);
            ypi2_d = (a_i1_q <<< FRAC) + (p_ri1_q + p_ir1_q);
            yqr2_d = (a_r1_q <<< FRAC) - (p_rr1_q - p_ii1_q);
            yqi2_d = (a_i1_q <<< FRAC) - (p_ri1_q + p_ir1_q);
        end else begin
            ypr2_d = a_r1_q;
            ypi2_d = a_i1_q;
            yqr2_d = b_r1_q * AW'(w_r1_q) - b_i1_q * AW'(w_i1_q);
            yqi2_d = b_r1_q * AW'(w_i1_q) + b_i1_q * AW'(w_r1_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q   <= 1'b0;
            m2_q   <= 1'b0;
            sc2_q  <= 1'b0;
            ypr2_q <= '0;
            ypi2_q <= '0;
            yqr2_q <= '0;
            yqi2_q <= '0;
        end else if (adv) begin
            v2_q <= v1_q;
            if (v1_q) begin
                m2_q   <= m1_q;
                sc2_q  <= sc1_q;
                ypr2_q <= ypr2_d;
                ypi2_q <= ypi2_d;
                yqr2_q <= yqr2_d;
                yqi2_q <= yqi2_d;
            end
        end
    end

    // Stage 3: DIF yp never saw a twiddle, so it drops only the optional scale bit.
    always_comb begin
        kq      = 8'(FRAC) + {7'd0, sc2_q};
        kp      = m2_q ? {7'd0, sc2_q} : kq;
        rpr     = round_k(ypr2_q, kp);
        rpi     = round_k(ypi2_q, kp);
        rqr     = round_k(yqr2_q, kq);
        rqi     = round_k(yqi2_q, kq);
        any_oor = out_of_range(rpr) || out_of_range(rpi) || out_of_range(rqr) || out_of_range(rqi);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            ypr_q       <= '0;
            ypi_q       <= '0;
            yqr_q       <= '0;
            yqi_q       <= '0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                ypr_q <= narrow(rpr);
                ypi_q <= narrow(rpi);
                yqr_q <= narrow(rqr);
                yqi_q <= narrow(rqi);
            end
        end
    end

`ifdef BUTTERFLY_PIPE_SAT_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          ovf_q <= 1'b0;
        else if (adv && v2_q && any_oor)    ovf_q <= 1'b1;
        else if (ovf_clr)                   ovf_q <= 1'b0;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr | any_oor;
    assign ovf        = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign yp_real   = ypr_q;
    assign yp_imag   = ypi_q;
    assign yq_real   = yqr_q;
    assign yq_imag   = yqi_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb/tb_butterfly_pipe.sv - scoreboard bench for butterfly_pipe with an arithmetic reference model
module tb_butterfly_pipe;

    localparam int DW   = 24;
    localparam int TW   = 16;
    localparam int FRAC = 13;
`ifdef BUTTERFLY_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint ypr, ypi, yqr, yqi;
        bit     ov;
        int     acc;
        bit     lat;
    } exp_t;

    logic clk, rstn, in_valid, in_ready, mode, scale, out_valid, out_ready, ovf_clr, ovf;
    logic signed [DW-1:0] xp_real, xp_imag, xq_real, xq_imag;
    logic signed [TW-1:0] factor_real, factor_imag;
    logic signed [DW-1:0] yp_real, yp_imag, yq_real, yq_imag;

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_fail = 0;
    int     cyc = 0;
    bit     rdy_mode = 0;
    bit     lat_mode = 1;
    bit     head_seen = 0;
    bit     hold_v = 0;
    bit     exp_ovf = 0;
    longint hold_y[4];

    butterfly_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .xp_real(xp_real), .xp_imag(xp_imag), .xq_real(xq_real), .xq_imag(xq_imag),
        .factor_real(factor_real), .factor_imag(factor_imag), .mode(mode), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .yp_real(yp_real), .yp_imag(yp_imag), .yq_real(yq_real), .yq_imag(yq_imag),
        .ovf_clr(ovf_clr), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: exact complex products, round half up by 2^k, then clamp or wrap.
    function automatic longint rnd(input longint v, input int k);
        if (k == 0) return v;
        return (v + (longint'(1) <<< (k - 1))) >>> k;
    endfunction

    function automatic bit oor(input longint v);
        return (v > (longint'(1) <<< (DW - 1)) - 1) || (v < -(longint'(1) <<< (DW - 1)));
    endfunction

    function automatic longint nar(input longint v);
        longint m;
        if (SAT) begin
            if (v > (longint'(1) <<< (DW - 1)) - 1) return (longint'(1) <<< (DW - 1)) - 1;
            if (v < -(longint'(1) <<< (DW - 1)))    return -(longint'(1) <<< (DW - 1));
            return v;
        end
        m = v & ((longint'(1) <<< DW) - 1);
        if (m >= (longint'(1) <<< (DW - 1))) m = m - (longint'(1) <<< DW);
        return m;
    endfunction

    function automatic exp_t model(input int xpr, xpi, xqr, xqi, wr, wi, input bit md, sc);
        exp_t   e;
        longint pr, pi, qr, qi, dr, di, unity;
        int     kp, kq;
        unity = longint'(1) <<< FRAC;
        if (!md) begin
            pr = longint'(xpr) * unity + (longint'(xqr) * wr - longint'(xqi) * wi);
            pi = longint'(xpi) * unity + (longint'(xqr) * wi + longint'(xqi) * wr);
            qr = longint'(xpr) * unity - (longint'(xqr) * wr - longint'(xqi) * wi);
            qi = longint'(xpi) * unity - (longint'(xqr) * wi + longint'(xqi) * wr);
            kp = FRAC + int'(sc);
        end else begin
            dr = longint'(xpr) - xqr;
            di = longint'(xpi) - xqi;
            pr = longint'(xpr) + xqr;
            pi = longint'(xpi) + xqi;
            qr = dr * wr - di * wi;
            qi = dr * wi + di * wr;
            kp = int'(sc);
        end
        kq = FRAC + int'(sc);
        pr = rnd(pr, kp);
        pi = rnd(pi, kp);
        qr = rnd(qr, kq);
        qi = rnd(qi, kq);
        e.ov  = SAT && (oor(pr) || oor(pi) || oor(qr) || oor(qi));
        e.ypr = nar(pr);
        e.ypi = nar(pi);
        e.yqr = nar(qr);
        e.yqi = nar(qi);
        e.acc = 0;
        e.lat = 0;
        return e;
    endfunction

    function automatic exp_t mk(input longint a, b, c, d, input bit ov);
        exp_t e;
        e.ypr = a; e.ypi = b; e.yqr = c; e.yqi = d; e.ov = ov; e.acc = 0; e.lat = 0;
        return e;
    endfunction

    function automatic int rs(input int bits);
        return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int xpr, xpi, xqr, xqi, wr, wi, input bit md, sc, input exp_t e);
        int w = 0;
        xp_real = DW'(xpr); xp_imag = DW'(xpi);
        xq_real = DW'(xqr); xq_imag = DW'(xqi);
        factor_real = TW'(wr); factor_imag = TW'(wi);
        mode = md; scale = sc; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        else begin
            e.acc = cyc;
            e.lat = lat_mode;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", sb.size(), 0);
        idle(1);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every output handshake; also checks hold stability and stall behaviour.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rstn) begin
            head_seen = 0;
            hold_v    = 0;
            exp_ovf   = 0;
        end else begin
            if (hold_v && out_valid) begin
                chk("hold_yp_real", yp_real, hold_y[0]);
                chk("hold_yp_imag", yp_imag, hold_y[1]);
                chk("hold_yq_real", yq_real, hold_y[2]);
                chk("hold_yq_imag", yq_imag, hold_y[3]);
            end
            if (out_valid && sb.size() > 0 && !head_seen) begin
                head_seen = 1;
                if (sb[0].lat) chk("latency", cyc - sb[0].acc, 3);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    e = sb.pop_front();
                    head_seen = 0;
                    exp_ovf = exp_ovf | e.ov;
                    chk("yp_real", yp_real, e.ypr);
                    chk("yp_imag", yp_imag, e.ypi);
                    chk("yq_real", yq_real, e.yqr);
                    chk("yq_imag", yq_imag, e.yqi);
                    chk("ovf", ovf, exp_ovf);
                end
            end
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", in_ready, 0);
                hold_y[0] = yp_real; hold_y[1] = yp_imag;
                hold_y[2] = yq_real; hold_y[3] = yq_imag;
                hold_v = 1;
            end else hold_v = 0;
            if (ovf_clr) exp_ovf = 0;
        end
    end

    initial begin
        int a, b, c, d, wr, wi;
        bit md, sc;
        rstn = 0; in_valid = 0; mode = 0; scale = 0; out_ready = 1; ovf_clr = 0;
        xp_real = '0; xp_imag = '0; xq_real = '0; xq_imag = '0;
        factor_real = '0; factor_imag = '0;
        idle(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_yp_real", yp_real, 0);
        chk("rst_yq_imag", yq_imag, 0);
        rstn = 1;
        idle(1);

        send(100, 0, 50, 0, 8192, 0, 0, 0, mk(150, 0, 50, 0, 0));
        send(100, 0, 50, 0, 8192, 0, 0, 1, mk(75, 0, 25, 0, 0));
        send(0, 0, 10, 20, 0, 8192, 0, 0, mk(-20, 10, 20, -10, 0));
        send(0, 0, 3, 0, 4096, 0, 0, 0, mk(2, 0, -1, 0, 0));
        send(3, 0, 2, 0, 8192, 0, 1, 1, mk(3, 0, 1, 0, 0));
        drain();

        send(8388607, 0, 1, 0, 8192, 0, 0, 0,
             mk(SAT ? 8388607 : -8388608, 0, 8388606, 0, SAT));
        drain();
        idle(2);
        chk("ovf_sticky", ovf, SAT);
        ovf_clr = 1;
        idle(1);
        ovf_clr = 0;
        chk("ovf_cleared", ovf, 0);

        lat_mode = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    a = rs(12); b = rs(12); c = rs(12); d = rs(12); wr = rs(14); wi = rs(14);
                    send(a, b, c, d, wr, wi, i[0], i[1], model(a, b, c, d, wr, wi, i[0], i[1]));
                end
            end
            begin
                idle(2);
                out_ready = 0;
                idle(5);
                out_ready = 1;
            end
        join
        drain();

        lat_mode = 1;
        send(11, 22, 33, 44, 8192, 0, 0, 0, model(11, 22, 33, 44, 8192, 0, 0, 0));
        send(55, 66, 77, 88, 0, 8192, 1, 0, model(55, 66, 77, 88, 0, 8192, 1, 0));
        send(99, 12, 13, 14, 4096, 4096, 0, 1, model(99, 12, 13, 14, 4096, 4096, 0, 1));
        rstn = 0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_yp_real", yp_real, 0);
        sb.delete();
        idle(2);
        rstn = 1;
        idle(1);
        send(100, 0, 50, 0, 8192, 0, 0, 0, mk(150, 0, 50, 0, 0));
        drain();

        for (int i = 0; i < 400; i++) begin
            if (i == 150) begin
                lat_mode = 0;
                rdy_mode = 1;
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 1) == 1) begin
                a = rs(24); b = rs(24); c = rs(24); d = rs(24);
            end else begin
                a = rs(12); b = rs(12); c = rs(12); d = rs(12);
            end
            case ($urandom_range(0, 3))
                0:       begin wr = 8192;  wi = 0;     end
                1:       begin wr = 0;     wi = -8192; end
                default: begin wr = rs(16); wi = rs(16); end
            endcase
            md = 1'($urandom_range(0, 1));
            sc = 1'($urandom_range(0, 1));
            send(a, b, c, d, wr, wi, md, sc, model(a, b, c, d, wr, wi, md, sc));
        end
        rdy_mode = 0;
        idle(1);
        out_ready = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
